// File: rtl/rf_writeback_queue_pkg.sv
// Shared sizing defaults and the write-request record for the register file
// writeback queue.
package rf_wb_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_WB_DEPTH = 4;
    localparam int PTR_W       = $clog2(RF_WB_DEPTH);

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Request, register-file write port and read-bypass signals of the
// writeback queue. The slave side is the queue itself.
interface rf_writeback_queue_if #(
    parameter int DEPTH = rf_wb_pkg::RF_WB_DEPTH,
    parameter int AW    = rf_wb_pkg::RF_AW,
    parameter int DW    = rf_wb_pkg::RF_DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          byp1_hit;
    logic [DW-1:0] byp1_data;
    logic          byp2_hit;
    logic [DW-1:0] byp2_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, ra1, ra2,
        output in_ready, we3, wa3, wd3, byp1_hit, byp1_data,
               byp2_hit, byp2_data, count, empty, full
    );

    modport master (
        output in_valid, in_addr, in_data, drain_en, ra1, ra2,
        input  in_ready, we3, wa3, wd3, byp1_hit, byp1_data,
               byp2_hit, byp2_data, count, empty, full
    );

endinterface

// File: rtl/rf_writeback_queue_bypass.sv
// Youngest-wins match of one read address against the pending writes:
// output register (oldest), then queue entries from head towards tail.
module rf_wb_bypass #(
    parameter  int DEPTH = rf_wb_pkg::RF_WB_DEPTH,
    parameter  int AW    = rf_wb_pkg::RF_AW,
    parameter  int DW    = rf_wb_pkg::RF_DW,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]             ra_i,
    input  logic [DEPTH-1:0][AW-1:0]  addr_i,
    input  logic [DEPTH-1:0][DW-1:0]  data_i,
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [PW-1:0]             head_i,
    input  logic                      out_vld_i,
    input  logic [AW-1:0]             out_addr_i,
    input  logic [DW-1:0]             out_data_i,
    output logic                      hit_o,
    output logic [DW-1:0]             data_o
);

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (out_vld_i && out_addr_i == ra_i) begin
            hit_o  = 1'b1;
            data_o = out_data_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PW'(i);
            if (valid_i[idx] && addr_i[idx] == ra_i) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
        // r0 is hardwired zero and never has a pending write.
        if (ra_i == '0) begin
            hit_o  = 1'b0;
            data_o = '0;
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding register file write port 3, with read
// bypass of writes that are queued or sitting in the output register.
module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_WB_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_writeback_queue_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     we3_q, we3_d;
    logic [AW-1:0]            wa3_q, wa3_d;
    logic [DW-1:0]            wd3_q, wd3_d;
    logic [DEPTH-1:0]         valid;
    logic                     full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Writes to r0 are acknowledged but dropped.
    assign push  = bus.in_valid && !full && (bus.in_addr != '0);
    assign pop   = bus.drain_en && !empty;

    // Pointer, occupancy and output-register next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop) begin
            head_d = head_q + 1'b1;
            we3_d  = 1'b1;
            wa3_d  = addr_q[head_q];
            wd3_d  = data_q[head_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    // Entry storage; occupancy alone decides validity, so no reset needed.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            addr_q[tail_q] <= bus.in_addr;
            data_q[tail_q] <= bus.in_data;
        end
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] age;
        age   = '0;
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            age      = PW'(j) - head_q;
            valid[j] = ({1'b0, age} < count_q);
        end
    end

    rf_wb_bypass #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp1 (
        .ra_i       (bus.ra1),
        .addr_i     (addr_q),
        .data_i     (data_q),
        .valid_i    (valid),
        .head_i     (head_q),
        .out_vld_i  (we3_q),
        .out_addr_i (wa3_q),
        .out_data_i (wd3_q),
        .hit_o      (bus.byp1_hit),
        .data_o     (bus.byp1_data)
    );

    rf_wb_bypass #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp2 (
        .ra_i       (bus.ra2),
        .addr_i     (addr_q),
        .data_i     (data_q),
        .valid_i    (valid),
        .head_i     (head_q),
        .out_vld_i  (we3_q),
        .out_addr_i (wa3_q),
        .out_data_i (wd3_q),
        .hit_o      (bus.byp2_hit),
        .data_o     (bus.byp2_data)
    );

    assign bus.in_ready = !full;
    assign bus.we3      = we3_q;
    assign bus.wa3      = wa3_q;
    assign bus.wd3      = wd3_q;
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed table-driven bench for rf_writeback_queue. Each row gives the
// inputs for one cycle and the outputs expected just before that cycle's
// rising edge (i.e. reflecting state left by the previous row).
module tb_rf_writeback_queue;
    import rf_wb_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    rf_writeback_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    rf_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          iv;
        logic [4:0]  ia;
        logic [31:0] id;
        bit          de;
        logic [4:0]  r1;
        logic [4:0]  r2;
        bit          rdy;
        int          cnt;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          h1;
        logic [31:0] d1;
        bit          h2;
        logic [31:0] d2;
    } vec_t;

    vec_t   vecs[$];
    rf_wr_t exp_wr[$];
    rf_wr_t got_wr[$];

    task automatic add(input bit rst_n, input bit iv, input logic [4:0] ia,
                       input logic [31:0] id, input bit de, input logic [4:0] r1,
                       input logic [4:0] r2, input bit rdy, input int cnt,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit h1, input logic [31:0] d1, input bit h2,
                       input logic [31:0] d2);
        vec_t v;
        v.rst_n = rst_n; v.iv = iv; v.ia = ia; v.id = id; v.de = de;
        v.r1 = r1; v.r2 = r2; v.rdy = rdy; v.cnt = cnt; v.we = we;
        v.wa = wa; v.wd = wd; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [4:0] ia, input logic [31:0] id,
                         input bit de, input logic [4:0] r1, input logic [4:0] r2);
        bus.in_valid = iv; bus.in_addr = ia; bus.in_data = id;
        bus.drain_en = de; bus.ra1 = r1; bus.ra2 = r2;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Single write, latency and bypass through the output register.
        add(1,1,5,32'hDEADBEEF,1,5,0, 1,0,0,0,32'h0,        0,32'h0,        0,32'h0);
        add(1,0,0,32'h0,1,5,0,        1,1,0,0,32'h0,        1,32'hDEADBEEF, 0,32'h0);
        add(1,0,0,32'h0,1,5,0,        1,0,1,5,32'hDEADBEEF, 1,32'hDEADBEEF, 0,32'h0);
        add(1,0,0,32'h0,0,5,0,        1,0,0,5,32'hDEADBEEF, 0,32'h0,        0,32'h0);
        // Fill to full, reject while full (also when a pop happens), drain.
        add(1,1,1,32'h11,0,1,4,       1,0,0,5,32'hDEADBEEF, 0,32'h0,  0,32'h0);
        add(1,1,2,32'h22,0,1,4,       1,1,0,5,32'hDEADBEEF, 1,32'h11, 0,32'h0);
        add(1,1,3,32'h33,0,1,4,       1,2,0,5,32'hDEADBEEF, 1,32'h11, 0,32'h0);
        add(1,1,4,32'h44,0,1,4,       1,3,0,5,32'hDEADBEEF, 1,32'h11, 0,32'h0);
        add(1,1,5,32'h55,0,1,4,       0,4,0,5,32'hDEADBEEF, 1,32'h11, 1,32'h44);
        add(1,1,5,32'h55,1,1,4,       0,4,0,5,32'hDEADBEEF, 1,32'h11, 1,32'h44);
        add(1,0,0,32'h0,1,1,4,        1,3,1,1,32'h11,       1,32'h11, 1,32'h44);
        add(1,0,0,32'h0,1,1,4,        1,2,1,2,32'h22,       0,32'h0,  1,32'h44);
        add(1,0,0,32'h0,1,1,4,        1,1,1,3,32'h33,       0,32'h0,  1,32'h44);
        add(1,0,0,32'h0,1,1,4,        1,0,1,4,32'h44,       0,32'h0,  1,32'h44);
        // Duplicate address: youngest wins over older entry and output reg.
        add(1,1,7,32'hA,0,0,7,        1,0,0,4,32'h44, 0,32'h0, 0,32'h0);
        add(1,1,7,32'hB,0,0,7,        1,1,0,4,32'h44, 0,32'h0, 1,32'hA);
        add(1,0,0,32'h0,1,0,7,        1,2,0,4,32'h44, 0,32'h0, 1,32'hB);
        add(1,0,0,32'h0,1,0,7,        1,1,1,7,32'hA,  0,32'h0, 1,32'hB);
        add(1,0,0,32'h0,1,0,7,        1,0,1,7,32'hB,  0,32'h0, 1,32'hB);
        add(1,0,0,32'h0,0,0,7,        1,0,0,7,32'hB,  0,32'h0, 0,32'h0);
        // r0 push dropped, push+pop on one edge, in-flight request not bypassed.
        add(1,1,1,32'h100,0,0,0,      1,0,0,7,32'hB,   0,32'h0,   0,32'h0);
        add(1,1,2,32'h200,0,0,0,      1,1,0,7,32'hB,   0,32'h0,   0,32'h0);
        add(1,1,0,32'h999,1,0,2,      1,2,0,7,32'hB,   0,32'h0,   1,32'h200);
        add(1,1,9,32'h900,1,0,9,      1,1,1,1,32'h100, 0,32'h0,   0,32'h0);
        add(1,0,0,32'h0,0,9,2,        1,1,1,2,32'h200, 1,32'h900, 1,32'h200);
        add(1,0,0,32'h0,1,9,2,        1,1,0,2,32'h200, 1,32'h900, 0,32'h0);
        add(1,0,0,32'h0,1,9,2,        1,0,1,9,32'h900, 1,32'h900, 0,32'h0);
        // Reset in the middle of a drain.
        add(1,1,3,32'h301,0,3,0,      1,0,0,9,32'h900, 0,32'h0,   0,32'h0);
        add(1,1,4,32'h401,0,3,0,      1,1,0,9,32'h900, 1,32'h301, 0,32'h0);
        add(1,1,5,32'h501,0,3,0,      1,2,0,9,32'h900, 1,32'h301, 0,32'h0);
        add(1,0,0,32'h0,1,3,0,        1,3,0,9,32'h900, 1,32'h301, 0,32'h0);
        add(0,1,6,32'h601,1,3,0,      1,2,1,3,32'h301, 1,32'h301, 0,32'h0);
        add(1,0,0,32'h0,1,3,5,        1,0,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(1,0,0,32'h0,1,3,5,        1,0,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(1,1,6,32'h600,1,6,0,      1,0,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(1,0,0,32'h0,1,6,0,        1,1,0,0,32'h0,   1,32'h600, 0,32'h0);
        add(1,0,0,32'h0,0,6,0,        1,0,1,6,32'h600, 1,32'h600, 0,32'h0);

        // Reset held two clocks while a request is offered.
        reset = 1'b0;
        drive(1, 5'd3, 32'h1234, 1, 5'd3, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full",  64'(bus.full),  64'd0);
        check("rst_we3",   64'(bus.we3),   64'd0);
        check("rst_wa3",   64'(bus.wa3),   64'd0);
        check("rst_wd3",   64'(bus.wd3),   64'd0);
        check("rst_hits",  64'({bus.byp1_hit, bus.byp2_hit}), 64'd0);
        reset = 1'b1;

        foreach (vecs[k]) begin
            vec_t v;
            bit   ok;
            v = vecs[k];
            reset = v.rst_n;
            drive(v.iv, v.ia, v.id, v.de, v.r1, v.r2);
            @(negedge clk);
            n_chk++;
            ok = (bus.in_ready === v.rdy) && (bus.count === 3'(v.cnt)) &&
                 (bus.empty === (v.cnt == 0)) && (bus.full === (v.cnt == 4)) &&
                 (bus.we3 === v.we) && (bus.wa3 === v.wa) && (bus.wd3 === v.wd) &&
                 (bus.byp1_hit === v.h1) && (bus.byp1_data === v.d1) &&
                 (bus.byp2_hit === v.h2) && (bus.byp2_data === v.d2);
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%0b cnt=%0d e=%0b f=%0b we=%0b wa=%0d wd=%0h b1=%0b/%0h b2=%0b/%0h expected rdy=%0b cnt=%0d we=%0b wa=%0d wd=%0h b1=%0b/%0h b2=%0b/%0h",
                         k, bus.in_ready, bus.count, bus.empty, bus.full, bus.we3, bus.wa3,
                         bus.wd3, bus.byp1_hit, bus.byp1_data, bus.byp2_hit, bus.byp2_data,
                         v.rdy, v.cnt, v.we, v.wa, v.wd, v.h1, v.d1, v.h2, v.d2);
            end
            @(posedge clk);
            #1;
        end

        // Wrapped fill then drain: writes must leave in acceptance order.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rf_wr_t w;
            w.addr = 5'(10 + i);
            w.data = 32'h1000 + 32'(i);
            exp_wr.push_back(w);
            drive(1, w.addr, w.data, 0, 5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);
        check("wrap_full", 64'(bus.full), 64'd1);
        for (int c = 0; c < 12 && got_wr.size() < 4; c++) begin
            @(negedge clk);
            if (bus.we3) begin
                rf_wr_t g;
                g.addr = bus.wa3;
                g.data = bus.wd3;
                got_wr.push_back(g);
            end
        end
        check("wrap_npop", 64'(got_wr.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_wr.size(); i++)
            check($sformatf("wrap_wr%0d", i), 64'(got_wr[i]), 64'(exp_wr[i]));
        check("wrap_empty", 64'(bus.empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side initiator for the 3-port register file. It buffers register write requests from execute/multi-cycle units in a small in-order queue.
- Drains one entry per cycle onto the register file write port (we3/wa3/wd3) when a write slot is granted.
- Provides read bypass of pending, not-yet-committed writes for the two register file read addresses, so readers see the youngest value.
- Sits between the datapath result muxes and the register file in the single-cycle/multi-cycle MIPS core.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, >=2)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- in_valid  input  1  write request present
- in_ready  output  1  queue can accept request this cycle
- in_addr  input  AW  destination register
- in_data  input  DW  write data
- drain_en  input  1  register file write slot available this cycle
- we3  output  1  register file write enable (registered)
- wa3  output  AW  register file write address (registered)
- wd3  output  DW  register file write data (registered)
- ra1  input  AW  register file read address 1
- ra2  input  AW  register file read address 2
- byp1_hit  output  1  pending write matches ra1
- byp1_data  output  DW  youngest pending data for ra1
- byp2_hit  output  1  pending write matches ra2
- byp2_data  output  DW  youngest pending data for ra2
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Reset (reset==0 at rising clk): head=tail=0, count=0, we3=0, wa3=0, wd3=0. All pending entries discarded, including mid-drain. Reset overrides every other event in that cycle.
- in_ready = !full (combinational from state only; no dependence on drain_en).
- Push: in_valid & in_ready at edge → entry {in_addr,in_data} written at tail, tail++ (mod DEPTH), count++.
- Register 0:
  - A push with in_addr==0 completes the handshake but stores nothing; count, tail and bypass are unchanged.
  - ra1/ra2==0 never hit.
- Pop: drain_en & !empty at edge → we3<=1, wa3<=head.addr, wd3<=head.data, head++, count--.
- No pop at edge → we3<=0; wa3/wd3 hold their previous values.
- Simultaneous push and pop: both occur, count unchanged. Pop uses the pre-edge head; an entry pushed in cycle N cannot pop before cycle N+1.
- Latency, empty queue, drain_en=1:
  - request accepted at edge N;
  - we3=1 after edge N+1;
  - register file commits at edge N+2.
- Full + in_valid: in_ready=0, no push, even if a pop occurs that edge.
- Pointer wrap: head/tail wrap modulo DEPTH; full/empty are derived from count, never from pointer equality.
- Bypass (combinational from state and ra1/ra2):
  - Candidates are every occupied queue entry plus the output register when we3==1 (committing next edge).
  - Priority: youngest queue entry (nearest tail) > older entries > output register.
  - byp_hit=0 → byp_data=0.
  - The in-flight request on in_* is not a candidate.
- Ordering: writes reach the register file strictly in acceptance order. Duplicate addresses are all written; the last one wins.

Decomposition:
- Package rf_wb_pkg:
  - RF_AW=5, RF_DW=32, RF_WB_DEPTH=4;
  - typedef rf_wr_t {addr[AW], data[DW]};
  - PTR_W localparam.
- Sub-module rf_wb_bypass: priority match of one read address against the entry array, valid mask and output register. Instantiated twice, for ra1 and ra2.

Test Plan:
1. Reset: hold reset=0 for 2 clocks with in_valid=1 → count=0, empty=1, we3=0, wa3=0, wd3=0, byp hits 0.
2. Single write, drain_en=1: push addr=5, data=0xDEADBEEF at edge N → edge N+1: we3=1, wa3=5, wd3=0xDEADBEEF. At edge N+2: we3=0. ra1=5 gives byp1_hit=1 with that data through cycle N+1.
3. Fill and stall: drain_en=0, push 4 writes (r1..r4 = 0x11..0x44) → full=1, in_ready=0. A 5th request is not accepted. Raise drain_en → we3 pulses 4 cycles with wa3 1,2,3,4 in order.
4. Bypass priority: drain_en=0, push r7=0xA then r7=0xB → byp2_data=0xB with ra2=7. After one pop: 0xB still, from queue. After second pop: 0xB from output reg; hit=0 next cycle.
5. Register 0 and simultaneous ops: count=2, drain_en=1, push addr=0 → handshake done, count=1 (pop only), no r0 write issued, ra1=0 no hit. Push r9 with pop on same edge → count unchanged.
6. Reset mid-drain: 3 entries queued, we3=1; assert reset one cycle → next cycle we3=0, count=0. No further writes issued.
